// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the RV64M multiply/divide unit.
//   OP_*           : RV64M funct3 encodings
//   muldiv_state_t : controller state
//   is_div/is_rem  : op classification helpers
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} muldiv_state_t;

  function automatic logic is_div(input logic [2:0] op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem(input logic [2:0] op);
    return op inside {OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: combinational sign conditioning.
//   a         : value in
//   is_signed : treat a as two's complement
//   inv       : request an extra negation
//   sign      : a is negative (only when is_signed)
//   y         : a negated when sign ^ inv, else a
// With inv=0 this yields |a| and its sign; with is_signed=0 it is a plain
// conditional negate used for result correction.
module muldiv_signfix #(
  parameter int N = 64
) (
  input  logic [N-1:0] a,
  input  logic         is_signed,
  input  logic         inv,
  output logic         sign,
  output logic [N-1:0] y
);
  assign sign = is_signed & a[N-1];
  assign y    = (sign ^ inv) ? -a : a;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M multiply/divide unit.
//   clk, rst_n        : clock, async active-low reset
//   start, op         : request (accepted when ready), RV64M funct3
//   dataA, dataB      : rs1 / rs2 operands
//   flush             : abort in-flight operation
//   ready             : unit idle
//   valid             : one-cycle result strobe
//   out               : result, held until next accepted start
//   Zero, Negative    : out==0 / out[N-1], only alongside valid
//   DivZero           : divide-type op with dataB==0, only alongside valid
// Multiply is shift-add over N cycles into a 2N accumulator; divide is
// restoring division over N cycles. Both run on magnitudes and the recorded
// sign is applied in DONE. Divide-by-zero and signed overflow skip straight
// to DONE.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] dataA,
  input  logic [N-1:0] dataB,
  input  logic         flush,
  output logic         ready,
  output logic         valid,
  output logic [N-1:0] out,
  output logic         Zero,
  output logic         Negative,
  output logic         DivZero
);
  localparam int CW = $clog2(N + 1);
  localparam logic [N-1:0] MIN_S = {1'b1, {(N-1){1'b0}}};

  muldiv_state_t  state;
  logic [2:0]     op_q;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] acc;   // {partial product, remaining multiplier bits}
  logic [N-1:0]   bop;   // multiplicand magnitude or divisor magnitude
  logic [N:0]     rem;
  logic [N-1:0]   quo;   // dividend shifts out the top, quotient bits in
  logic           neg_q;
  logic           dz_q;

  // operand conditioning: index 0 = dataA, 1 = dataB
  logic [1:0][N-1:0] opnd, mag;
  logic [1:0]        sgn_en, sgn;

  assign opnd      = {dataB, dataA};
  assign sgn_en[0] = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign sgn_en[1] = op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};

  for (genvar g = 0; g < 2; g++) begin : g_opfix
    muldiv_signfix #(.N(N)) u_opfix (
      .a         (opnd[g]),
      .is_signed (sgn_en[g]),
      .inv       (1'b0),
      .sign      (sgn[g]),
      .y         (mag[g])
    );
  end

  logic div0, ovf;
  assign div0 = is_div(op) && (dataB == '0);
  assign ovf  = (op == OP_DIV || op == OP_REM) && (dataA == MIN_S) && (dataB == '1);

  // one iteration step of each algorithm
  logic [N:0] mul_sum, shl, trial;
  assign mul_sum = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, bop} : '0);
  assign shl     = {rem[N-1:0], quo[N-1]};
  assign trial   = shl - {1'b0, bop};

  // rem[N] stays zero after every step; it is kept for the trial width only
  logic rem_top_unused;
  assign rem_top_unused = rem[N];

  // result correction: one 2N negate covers both the product and the
  // zero-extended quotient/remainder
  logic [2*N-1:0] raw, res2;
  logic [N-1:0]   res;
  logic           res_sign_unused;

  assign raw = is_div(op_q) ? {{N{1'b0}}, (is_rem(op_q) ? rem[N-1:0] : quo)} : acc;

  muldiv_signfix #(.N(2*N)) u_resfix (
    .a         (raw),
    .is_signed (1'b0),
    .inv       (neg_q),
    .sign      (res_sign_unused),
    .y         (res2)
  );

  assign res   = (is_div(op_q) || op_q == OP_MUL) ? res2[N-1:0] : res2[2*N-1:N];
  assign ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= '0;
      cnt      <= '0;
      acc      <= '0;
      bop      <= '0;
      rem      <= '0;
      quo      <= '0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      valid    <= 1'b0;
      out      <= '0;
      Zero     <= 1'b0;
      Negative <= 1'b0;
      DivZero  <= 1'b0;
    end else begin
      // flags only ever accompany valid
      valid    <= 1'b0;
      Zero     <= 1'b0;
      Negative <= 1'b0;
      DivZero  <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (start) begin
            op_q  <= op;
            dz_q  <= div0;
            neg_q <= is_rem(op) ? sgn[0] : (sgn[0] ^ sgn[1]);
            cnt   <= CW'(N);
            if (div0) begin
              quo   <= '1;
              rem   <= {1'b0, dataA};
              neg_q <= 1'b0;
              state <= DONE;
            end else if (ovf) begin
              quo   <= dataA;
              rem   <= '0;
              neg_q <= 1'b0;
              state <= DONE;
            end else if (is_div(op)) begin
              rem   <= '0;
              quo   <= mag[0];
              bop   <= mag[1];
              state <= DIV;
            end else begin
              acc   <= {{N{1'b0}}, mag[1]};
              bop   <= mag[0];
              state <= MUL;
            end
          end
          MUL: begin
            acc <= {mul_sum, acc[N-1:1]};
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) state <= DONE;
          end
          DIV: begin
            rem <= trial[N] ? shl : trial;
            quo <= {quo[N-2:0], ~trial[N]};
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) state <= DONE;
          end
          DONE: begin
            out      <= res;
            valid    <= 1'b1;
            Zero     <= (res == '0);
            Negative <= res[N-1];
            DivZero  <= dz_q;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] op = '0;
  logic [7:0] dataA = '0;
  logic [7:0] dataB = '0;
  logic       ready, valid, Zero, Negative, DivZero;
  logic [7:0] out;

  int checks = 0;
  int errors = 0;

  logic [7:0] r_out;
  logic       r_z, r_n, r_dz, r_rdy_low;
  int         r_lat;

  muldiv_unit #(.N(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .dataA    (dataA),
    .dataB    (dataB),
    .flush    (flush),
    .ready    (ready),
    .valid    (valid),
    .out      (out),
    .Zero     (Zero),
    .Negative (Negative),
    .DivZero  (DivZero)
  );

  always #5 clk = ~clk;

  // issue one op, wait (bounded) for valid; latency counted in edges after accept
  task automatic run(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    op = o; dataA = a; dataB = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    r_lat = -1; r_rdy_low = 1'b1;
    r_out = 'x; r_z = 1'bx; r_n = 1'bx; r_dz = 1'bx;
    if (ready) r_rdy_low = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid) begin
        r_lat = k; r_out = out; r_z = Zero; r_n = Negative; r_dz = DivZero;
        break;
      end
      if (ready) r_rdy_low = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #10;
    checks++;
    if ({ready, valid, out, Zero, Negative, DivZero} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b out=%h z=%b n=%b dz=%b exp 1 0 00 0 0 0",
               ready, valid, out, Zero, Negative, DivZero);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_mul();
    run(OP_MUL, 8'd7, 8'hFD);
    checks++;
    if (r_lat !== 9) begin errors++; $display("FAIL mul_latency got %0d exp 9", r_lat); end
    checks++;
    if ({r_out, r_n, r_z} !== {8'hEB, 1'b1, 1'b0}) begin
      errors++; $display("FAIL mul_result got out=%h n=%b z=%b exp EB 1 0", r_out, r_n, r_z);
    end
    checks++;
    if (r_rdy_low !== 1'b1) begin errors++; $display("FAIL mul_ready_low got ready high during op exp low"); end
  endtask

  task automatic test_mulh();
    run(OP_MULHU, 8'hFF, 8'hFF);
    checks++;
    if (r_out !== 8'hFE) begin errors++; $display("FAIL mulhu got %h exp FE", r_out); end
    run(OP_MULH, 8'hFF, 8'hFF);
    checks++;
    if ({r_out, r_z} !== {8'h00, 1'b1}) begin errors++; $display("FAIL mulh got %h z=%b exp 00 1", r_out, r_z); end
    run(OP_MULHSU, 8'hFF, 8'h02);
    checks++;
    if ({r_out, r_n} !== {8'hFF, 1'b1}) begin errors++; $display("FAIL mulhsu got %h n=%b exp FF 1", r_out, r_n); end
  endtask

  task automatic test_div();
    run(OP_DIV, 8'hF9, 8'd2);
    checks++;
    if ({r_out, r_lat} !== {8'hFD, 32'd9}) begin errors++; $display("FAIL div got %h lat %0d exp FD 9", r_out, r_lat); end
    run(OP_REM, 8'hF9, 8'd2);
    checks++;
    if (r_out !== 8'hFF) begin errors++; $display("FAIL rem got %h exp FF", r_out); end
    run(OP_DIVU, 8'd20, 8'd3);
    checks++;
    if ({r_out, r_dz} !== {8'd6, 1'b0}) begin errors++; $display("FAIL divu got %h dz=%b exp 06 0", r_out, r_dz); end
    run(OP_REMU, 8'd20, 8'd3);
    checks++;
    if (r_out !== 8'd2) begin errors++; $display("FAIL remu got %h exp 02", r_out); end
  endtask

  task automatic test_fastpath();
    run(OP_DIVU, 8'd20, 8'd0);
    checks++;
    if ({r_lat, r_out, r_dz} !== {32'd1, 8'hFF, 1'b1}) begin
      errors++; $display("FAIL divu_by0 got lat %0d out %h dz %b exp 1 FF 1", r_lat, r_out, r_dz);
    end
    run(OP_REMU, 8'd20, 8'd0);
    checks++;
    if ({r_out, r_dz} !== {8'h14, 1'b1}) begin errors++; $display("FAIL remu_by0 got %h dz %b exp 14 1", r_out, r_dz); end
    run(OP_DIV, 8'h80, 8'hFF);
    checks++;
    if ({r_lat, r_out, r_dz} !== {32'd1, 8'h80, 1'b0}) begin
      errors++; $display("FAIL div_ovf got lat %0d out %h dz %b exp 1 80 0", r_lat, r_out, r_dz);
    end
    run(OP_REM, 8'h80, 8'hFF);
    checks++;
    if ({r_out, r_z} !== {8'h00, 1'b1}) begin errors++; $display("FAIL rem_ovf got %h z %b exp 00 1", r_out, r_z); end
  endtask

  task automatic test_ignored_start();
    int nvalid = 0;
    int first = -1;
    logic [7:0] got = 'x;
    @(negedge clk);
    op = OP_MUL; dataA = 8'd7; dataB = 8'hFD; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      start = (k == 3);
      if (k == 3) begin op = OP_DIVU; dataA = 8'd9; dataB = 8'd3; end
      if (valid) begin
        nvalid++;
        if (first < 0) begin first = k; got = out; end
      end
    end
    start = 1'b0;
    checks++;
    if (nvalid !== 1) begin errors++; $display("FAIL ignored_start_count got %0d valids exp 1", nvalid); end
    checks++;
    if ({first, got} !== {32'd9, 8'hEB}) begin
      errors++; $display("FAIL ignored_start_result got lat %0d out %h exp 9 EB", first, got);
    end
  endtask

  task automatic test_back_to_back();
    run(OP_DIVU, 8'd20, 8'd3);
    // run() starts on the next falling edge, i.e. the cycle after valid
    run(OP_MUL, 8'd5, 8'd6);
    checks++;
    if ({r_lat, r_out} !== {32'd9, 8'd30}) begin
      errors++; $display("FAIL back_to_back got lat %0d out %h exp 9 1E", r_lat, r_out);
    end
  endtask

  task automatic test_flush();
    int nvalid = 0;
    run(OP_DIVU, 8'd20, 8'd3);   // out = 06
    @(negedge clk);
    op = OP_DIV; dataA = 8'hF9; dataB = 8'd2; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if ({ready, valid} !== 2'b10) begin errors++; $display("FAIL flush_idle got rdy=%b vld=%b exp 1 0", ready, valid); end
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (valid) nvalid++;
    end
    checks++;
    if ({nvalid, out} !== {32'd0, 8'h06}) begin
      errors++; $display("FAIL flush_no_valid got %0d valids out %h exp 0 06", nvalid, out);
    end
    // flush during the DONE cycle of a fast path
    op = OP_DIVU; dataA = 8'd20; dataB = 8'd0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if ({ready, valid, DivZero, out} !== {3'b100, 8'h06}) begin
      errors++; $display("FAIL flush_done got rdy=%b vld=%b dz=%b out=%h exp 1 0 0 06", ready, valid, DivZero, out);
    end
    // flush in IDLE blocks a same-cycle start
    op = OP_MUL; dataA = 8'd3; dataB = 8'd3; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL flush_blocks_start got ready=%b exp 1", ready); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    op = OP_DIV; dataA = 8'hF9; dataB = 8'd2; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ready, valid, out} !== {2'b10, 8'h00}) begin
      errors++; $display("FAIL reset_mid got rdy=%b vld=%b out=%h exp 1 0 00", ready, valid, out);
    end
    @(negedge clk) rst_n = 1'b1;
    run(OP_DIVU, 8'd9, 8'd3);
    checks++;
    if (r_out !== 8'd3) begin errors++; $display("FAIL after_reset got %h exp 03", r_out); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_fastpath();
    test_ignored_start();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
